cook_controller: RTL and testbench

COOK_CONTROLLER -- requirements
Module: cook_controller

---
 rtl/cook_controller_pkg.sv | 20 ++
 rtl/cook_controller_edge_detect.sv | 24 ++
 rtl/cook_controller.sv | 108 ++++++++++
 tb/tb_cook_controller.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cook_controller_pkg.sv
// Shared definitions for the cook controller: state encodings and the beep default.
// The display logic imports the same state encodings.
package cook_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTING = 3'd1,
        ST_COOKING = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_DONE    = 3'd4
    } cook_state_e;

    localparam int BEEP_SECONDS_DEFAULT = 3;

    // The tick counter must be at least one bit wide, even for a zero-length beep
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cook_controller_edge_detect.sv
// Single-cycle pulse on a rising (RISE=1) or falling (RISE=0) edge of sig.
// RESET_VAL seeds the history so a level held through reset does not fire.
module edge_detect #(
    parameter logic RISE      = 1'b1,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic clear,
    input  logic sig,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk) begin
        if (clear)
            prev <= RESET_VAL;
        else
            prev <= sig;
    end

    assign pulse = RISE ? (sig & ~prev) : (~sig & prev);

endmodule

// File: rtl/cook_controller.sv
// Microwave cook controller FSM with registered Moore outputs.
// Define COOK_DONE_BEEP_EN to hold the completion beep for BEEP_SECONDS 1 Hz ticks.
module cook_controller
    import cook_controller_pkg::*;
#(
    parameter int BEEP_SECONDS = BEEP_SECONDS_DEFAULT
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       timer_zero,
    output logic       enablen,
    output logic       timer_clear,
    output logic       mag_on,
    output logic       beep,
    output logic [2:0] state
);

    logic start_pulse, stop_pulse, tick;
    logic start_ev, stop_ev;
    logic beep_done;
    cook_state_e cur, nxt;

    // Keys are active-low, so a press is a falling edge; history starts "pressed"
    edge_detect #(.RISE(1'b0), .RESET_VAL(1'b0)) u_start (
        .clk(clk), .clear(clear), .sig(startn), .pulse(start_pulse)
    );
    edge_detect #(.RISE(1'b0), .RESET_VAL(1'b0)) u_stop (
        .clk(clk), .clear(clear), .sig(stopn), .pulse(stop_pulse)
    );
    edge_detect #(.RISE(1'b1), .RESET_VAL(1'b1)) u_tick (
        .clk(clk), .clear(clear), .sig(pgt_1Hz), .pulse(tick)
    );

    assign stop_ev  = stop_pulse;
    assign start_ev = start_pulse & ~stop_pulse;
    assign state    = cur;

`ifdef COOK_DONE_BEEP_EN
    localparam int CW = cnt_width(BEEP_SECONDS);
    localparam logic [CW:0] BEEP_MAX = (CW + 1)'(BEEP_SECONDS);

    logic [CW-1:0] tick_cnt;
    logic [CW:0]   cnt_after;

    // Count including this cycle's tick, so the exit lands on the final tick
    assign cnt_after = {1'b0, tick_cnt} + {{CW{1'b0}}, tick};
    assign beep_done = (cnt_after >= BEEP_MAX);
`else
    logic unused_tick;
    assign unused_tick = tick;
    assign beep_done   = 1'b1;
    assign beep        = 1'b0;
`endif

    always_comb begin
        nxt = cur;
        case (cur)
            ST_IDLE:    if (!loadn) nxt = ST_SETTING;
            ST_SETTING,
            ST_PAUSED: begin
                if (stop_ev)
                    nxt = ST_IDLE;
                else if (start_ev && door_closed && !timer_zero)
                    nxt = ST_COOKING;
            end
            ST_COOKING: begin
                if (timer_zero)
                    nxt = ST_DONE;
                else if (!door_closed || stop_ev)
                    nxt = ST_PAUSED;
            end
            ST_DONE:    if (stop_ev || beep_done) nxt = ST_IDLE;
            default:    nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as state
    always_ff @(posedge clk) begin
        if (clear) begin
            cur         <= ST_IDLE;
            enablen     <= 1'b1;
            mag_on      <= 1'b0;
            timer_clear <= 1'b0;
`ifdef COOK_DONE_BEEP_EN
            beep        <= 1'b0;
            tick_cnt    <= '0;
`endif
        end else begin
            cur         <= nxt;
            enablen     <= (nxt != ST_COOKING);
            mag_on      <= (nxt == ST_COOKING);
            timer_clear <= (cur != ST_IDLE) && (nxt == ST_IDLE);
`ifdef COOK_DONE_BEEP_EN
            beep        <= (nxt == ST_DONE);
            if (nxt == ST_DONE && cur != ST_DONE)
                tick_cnt <= '0;
            else if (cur == ST_DONE && tick && ({1'b0, tick_cnt} < BEEP_MAX))
                tick_cnt <= tick_cnt + 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_cook_controller.sv
// Self-checking bench for cook_controller: table of per-cycle vectors plus
// hand-written multi-cycle sequences, checked through an expected-value queue.
module tb_cook_controller;

    localparam logic [2:0] S_I = 3'd0;
    localparam logic [2:0] S_S = 3'd1;
    localparam logic [2:0] S_C = 3'd2;
    localparam logic [2:0] S_P = 3'd3;
    localparam logic [2:0] S_D = 3'd4;

`ifdef COOK_DONE_BEEP_EN
    localparam logic BEEP_EN = 1'b1;
`else
    localparam logic BEEP_EN = 1'b0;
`endif

    typedef struct {
        logic clear, startn, stopn, door_closed, loadn, pgt_1Hz, timer_zero;
    } stim_t;

    typedef struct {
        logic [2:0] state;
        logic       mag_on, enablen, timer_clear, beep;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic clk = 1'b0;
    logic clear = 1'b1, startn = 1'b1, stopn = 1'b1, door_closed = 1'b1;
    logic loadn = 1'b1, pgt_1Hz = 1'b0, timer_zero = 1'b0;
    logic enablen, timer_clear, mag_on, beep;
    logic [2:0] state;

    int tests_run = 0;
    int tests_failed = 0;
    exp_t sb[$];
    vec_t vecs[$];

    cook_controller #(.BEEP_SECONDS(3)) dut (
        .clk(clk), .clear(clear), .startn(startn), .stopn(stopn),
        .door_closed(door_closed), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
        .timer_zero(timer_zero), .enablen(enablen), .timer_clear(timer_clear),
        .mag_on(mag_on), .beep(beep), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Build one cycle's vector; Moore outputs follow from the expected state
    function automatic vec_t v(input logic clr, st, sp, dr, ld, pg, tz,
                               input logic [2:0] es, input logic et);
        vec_t r;
        r.s.clear = clr; r.s.startn = st; r.s.stopn = sp; r.s.door_closed = dr;
        r.s.loadn = ld;  r.s.pgt_1Hz = pg; r.s.timer_zero = tz;
        r.e.state       = es;
        r.e.mag_on      = (es == S_C);
        r.e.enablen     = (es != S_C);
        r.e.timer_clear = et;
        r.e.beep        = BEEP_EN && (es == S_D);
        return r;
    endfunction

    task automatic cmp(input string tag, input string field, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s.%s: got %0d, expected %0d", tag, field, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t x);
        clear = x.s.clear; startn = x.s.startn; stopn = x.s.stopn;
        door_closed = x.s.door_closed; loadn = x.s.loadn;
        pgt_1Hz = x.s.pgt_1Hz; timer_zero = x.s.timer_zero;
        sb.push_back(x.e);
    endtask

    task automatic check_output(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s.queue: got empty, expected an entry", tag);
            return;
        end
        e = sb.pop_front();
        cmp(tag, "state",       int'(state),       int'(e.state));
        cmp(tag, "mag_on",      int'(mag_on),      int'(e.mag_on));
        cmp(tag, "enablen",     int'(enablen),     int'(e.enablen));
        cmp(tag, "timer_clear", int'(timer_clear), int'(e.timer_clear));
        cmp(tag, "beep",        int'(beep),        int'(e.beep));
    endtask

    task automatic step(input vec_t x, input string tag);
        apply_stimulus(x);
        @(posedge clk);
        #1;
        check_output(tag);
    endtask

    initial begin
        //          clr st sp dr ld pg tz  state tclr
        vecs.push_back(v(1, 1, 1, 1, 1, 0, 0, S_I, 0));  // reset
        vecs.push_back(v(0, 1, 1, 1, 1, 0, 0, S_I, 0));
        vecs.push_back(v(0, 0, 1, 1, 1, 0, 0, S_I, 0));  // start ignored in IDLE
        vecs.push_back(v(0, 1, 1, 1, 1, 0, 0, S_I, 0));
        vecs.push_back(v(0, 1, 1, 1, 0, 0, 0, S_S, 0));  // keypad digit
        vecs.push_back(v(0, 1, 1, 1, 1, 0, 0, S_S, 0));
        vecs.push_back(v(0, 0, 1, 0, 1, 0, 0, S_S, 0));  // start, door open
        vecs.push_back(v(0, 1, 1, 1, 1, 0, 0, S_S, 0));
        vecs.push_back(v(0, 0, 1, 1, 1, 0, 1, S_S, 0));  // start, timer zero
        vecs.push_back(v(0, 1, 1, 1, 1, 0, 0, S_S, 0));
        vecs.push_back(v(0, 0, 1, 1, 1, 0, 0, S_C, 0));  // valid start
        vecs.push_back(v(0, 1, 1, 1, 1, 0, 0, S_C, 0));
        vecs.push_back(v(0, 1, 1, 0, 1, 0, 0, S_P, 0));  // door opens
        vecs.push_back(v(0, 1, 1, 1, 1, 0, 0, S_P, 0));
        vecs.push_back(v(0, 0, 1, 1, 1, 0, 0, S_C, 0));  // resume
        vecs.push_back(v(0, 1, 1, 1, 1, 0, 0, S_C, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0, 0, S_P, 0));  // stop pauses
        vecs.push_back(v(0, 1, 1, 1, 1, 0, 0, S_P, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0, 0, S_I, 1));  // stop cancels
        vecs.push_back(v(0, 1, 1, 1, 1, 0, 0, S_I, 0));
        vecs.push_back(v(0, 1, 1, 1, 0, 0, 0, S_S, 0));
        vecs.push_back(v(0, 1, 1, 1, 1, 0, 0, S_S, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, S_I, 1));  // start+stop = stop
        vecs.push_back(v(0, 1, 1, 1, 1, 0, 0, S_I, 0));
        vecs.push_back(v(0, 1, 1, 1, 0, 0, 0, S_S, 0));
        vecs.push_back(v(0, 0, 1, 1, 1, 0, 0, S_C, 0));
        vecs.push_back(v(0, 1, 1, 1, 1, 0, 0, S_C, 0));
        vecs.push_back(v(0, 1, 1, 1, 0, 0, 0, S_C, 0));  // keypad ignored
        vecs.push_back(v(0, 1, 0, 1, 1, 0, 1, S_D, 0));  // zero beats stop

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], $sformatf("vec%0d", i));

`ifdef COOK_DONE_BEEP_EN
        step(v(0, 1, 1, 1, 1, 0, 0, S_D, 0), "beep_wait");
        step(v(0, 1, 1, 1, 1, 1, 0, S_D, 0), "beep_tick1");
        step(v(0, 1, 1, 1, 1, 0, 0, S_D, 0), "beep_low1");
        step(v(0, 1, 1, 1, 1, 1, 0, S_D, 0), "beep_tick2");
        step(v(0, 1, 1, 1, 1, 0, 0, S_D, 0), "beep_low2");
        step(v(0, 1, 1, 1, 1, 1, 0, S_I, 1), "beep_tick3");
        step(v(0, 1, 1, 1, 1, 0, 0, S_I, 0), "beep_after");
`else
        step(v(0, 1, 1, 1, 1, 0, 0, S_I, 1), "done_exit");
        step(v(0, 1, 1, 1, 1, 0, 0, S_I, 0), "done_after");
`endif

        // Held start key produces a single COOKING entry
        step(v(0, 1, 1, 1, 0, 0, 0, S_S, 0), "hold_load");
        step(v(0, 1, 1, 1, 1, 0, 0, S_S, 0), "hold_idle");
        for (int i = 0; i < 100; i++)
            step(v(0, 0, 1, 1, 1, 0, 0, S_C, 0), $sformatf("hold%0d", i));
        step(v(0, 0, 0, 1, 1, 0, 0, S_P, 0), "hold_stop");
        step(v(0, 0, 1, 1, 1, 0, 0, S_P, 0), "hold_stop_rel");

        // Start held low through reset must not fire until re-pressed
        step(v(1, 0, 1, 1, 1, 0, 0, S_I, 0), "rst_held");
        step(v(0, 0, 1, 1, 0, 0, 0, S_S, 0), "rst_load");
        for (int i = 0; i < 3; i++)
            step(v(0, 0, 1, 1, 1, 0, 0, S_S, 0), $sformatf("rst_still%0d", i));
        step(v(0, 1, 1, 1, 1, 0, 0, S_S, 0), "rst_release");
        step(v(0, 0, 1, 1, 1, 0, 0, S_C, 0), "rst_repress");

        // Reset mid-COOKING
        step(v(0, 1, 1, 1, 1, 0, 0, S_C, 0), "mid_cook");
        step(v(1, 1, 1, 1, 1, 0, 0, S_I, 0), "mid_clear");
        step(v(0, 1, 1, 1, 1, 0, 0, S_I, 0), "mid_after");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
